// File: rtl/iob_cache_fe_arbiter.sv
// ---------------------------------------------------------------------------
// iob_cache_fe_arbiter
//
// Shares the single IOb front-end port of the cache between two requesters
// (typically a CPU's instruction and data buses).
//   - Round-robin grant; the grant is locked while the cache stalls (ready=0).
//   - Read requests push the requester ID into an in-order FIFO so each
//     rvalid/rdata response is routed back to the requester that issued it.
//   - Forwarding and response routing are purely combinational.
//
// Ports
//   clk_i, cke_i, arst_n_i          clock, clock enable, async active-low reset
//   m0_iob_*, m1_iob_*              requester-side IOb ports (valid/addr/wdata/
//                                   wstrb in, ready/rvalid/rdata out)
//   s_iob_*                         cache-side IOb port
//   pend_o                          number of outstanding reads (0..2^PEND_W)
//   err_o                           sticky: rvalid arrived with no read pending
// ---------------------------------------------------------------------------
module iob_cache_fe_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int PEND_W = 1
) (
    input  logic                clk_i,
    input  logic                cke_i,
    input  logic                arst_n_i,

    input  logic                m0_iob_valid_i,
    input  logic [ADDR_W-1:0]   m0_iob_addr_i,
    input  logic [DATA_W-1:0]   m0_iob_wdata_i,
    input  logic [DATA_W/8-1:0] m0_iob_wstrb_i,
    output logic                m0_iob_ready_o,
    output logic                m0_iob_rvalid_o,
    output logic [DATA_W-1:0]   m0_iob_rdata_o,

    input  logic                m1_iob_valid_i,
    input  logic [ADDR_W-1:0]   m1_iob_addr_i,
    input  logic [DATA_W-1:0]   m1_iob_wdata_i,
    input  logic [DATA_W/8-1:0] m1_iob_wstrb_i,
    output logic                m1_iob_ready_o,
    output logic                m1_iob_rvalid_o,
    output logic [DATA_W-1:0]   m1_iob_rdata_o,

    output logic                s_iob_valid_o,
    output logic [ADDR_W-1:0]   s_iob_addr_o,
    output logic [DATA_W-1:0]   s_iob_wdata_o,
    output logic [DATA_W/8-1:0] s_iob_wstrb_o,
    input  logic                s_iob_ready_i,
    input  logic                s_iob_rvalid_i,
    input  logic [DATA_W-1:0]   s_iob_rdata_i,

    output logic [PEND_W:0]     pend_o,
    output logic                err_o
);

    localparam int              DEPTH    = 1 << PEND_W;
    localparam logic [PEND_W:0] PEND_MAX = DEPTH[PEND_W:0];

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t              state_reg, state_next;
    logic                gnt_reg, gnt_next;
    logic                prio_reg, prio_next;
    logic [PEND_W-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [PEND_W:0]     pend_reg, pend_next;
    logic                err_reg;
    logic                id_mem [DEPTH];

    logic                gnt_vld;
    logic                gnt_id;
    logic                full;
    logic                empty;
    logic                accept;
    logic                push;
    logic                pop;
    logic                head;

    assign full  = (pend_reg == PEND_MAX);
    assign empty = (pend_reg == '0);
    assign head  = id_mem[rd_ptr_reg];

    // Grant selection. In HOLD the locked requester is the only candidate;
    // its valid dropping simply yields no grant (and the FSM falls to IDLE).
    // A full FIFO stalls every request, writes included, to keep ordering
    // trivially correct.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = 1'b0;
        if (state_reg == HOLD) begin
            gnt_id  = gnt_reg;
            gnt_vld = gnt_reg ? m1_iob_valid_i : m0_iob_valid_i;
        end else if (!full) begin
            if (m0_iob_valid_i && m1_iob_valid_i) begin
                gnt_vld = 1'b1;
                gnt_id  = prio_reg;
            end else if (m0_iob_valid_i || m1_iob_valid_i) begin
                gnt_vld = 1'b1;
                gnt_id  = m1_iob_valid_i;
            end
        end
        // Keep every request-side output quiet while reset is asserted.
        if (!arst_n_i) begin
            gnt_vld = 1'b0;
        end
    end

    assign s_iob_valid_o  = gnt_vld;
    assign s_iob_addr_o   = !gnt_vld ? '0 : (gnt_id ? m1_iob_addr_i  : m0_iob_addr_i);
    assign s_iob_wdata_o  = !gnt_vld ? '0 : (gnt_id ? m1_iob_wdata_i : m0_iob_wdata_i);
    assign s_iob_wstrb_o  = !gnt_vld ? '0 : (gnt_id ? m1_iob_wstrb_i : m0_iob_wstrb_i);
    assign m0_iob_ready_o = gnt_vld & ~gnt_id & s_iob_ready_i;
    assign m1_iob_ready_o = gnt_vld &  gnt_id & s_iob_ready_i;

    assign accept = gnt_vld & s_iob_ready_i;
    assign push   = accept & (s_iob_wstrb_o == '0);
    // The cache never answers in the acceptance cycle, so a pop always refers
    // to the head as it stood before any same-cycle push.
    assign pop    = s_iob_rvalid_i & ~empty;

    assign m0_iob_rvalid_o = arst_n_i & pop & ~head;
    assign m1_iob_rvalid_o = arst_n_i & pop &  head;
    assign m0_iob_rdata_o  = s_iob_rdata_i;
    assign m1_iob_rdata_o  = s_iob_rdata_i;

    assign pend_o = pend_reg;
    assign err_o  = err_reg;

    // Next-state logic for the grant FSM and round-robin pointer.
    always_comb begin
        state_next = IDLE;
        gnt_next   = gnt_reg;
        prio_next  = prio_reg;
        if (accept) begin
            prio_next = ~gnt_id;
        end else if (gnt_vld) begin
            state_next = HOLD;
            gnt_next   = gnt_id;
        end
    end

    always_comb begin
        pend_next = pend_reg;
        case ({push, pop})
            2'b10:   pend_next = pend_reg + 1'b1;
            2'b01:   pend_next = pend_reg - 1'b1;
            default: pend_next = pend_reg;
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_reg  <= IDLE;
            gnt_reg    <= 1'b0;
            prio_reg   <= 1'b0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            pend_reg   <= '0;
            err_reg    <= 1'b0;
        end else if (cke_i) begin
            state_reg <= state_next;
            gnt_reg   <= gnt_next;
            prio_reg  <= prio_next;
            pend_reg  <= pend_next;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (s_iob_rvalid_i && empty) begin
                err_reg <= 1'b1;
            end
        end
    end

    // Requester-ID storage; small enough that plain registers give the
    // combinational head read the response path needs.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                id_mem[i] <= 1'b0;
            end
        end else if (cke_i && push) begin
            id_mem[wr_ptr_reg] <= gnt_id;
        end
    end

endmodule

// File: tb/tb_iob_cache_fe_arbiter.sv
// ---------------------------------------------------------------------------
// Testbench for iob_cache_fe_arbiter.
// A stimulus process drives random requesters and a random-latency cache
// model, and pushes the expected per-cycle response of the arbiter into a
// scoreboard queue; a monitor pops and compares on the falling edge.
// Directed sections cover reset, the unsolicited-rvalid error and a write.
// ---------------------------------------------------------------------------
module tb_iob_cache_fe_arbiter;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        cke;
    logic        arst_n;
    logic        m0_valid, m1_valid;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic        m0_ready, m1_ready, m0_rvalid, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_valid;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_ready, s_rvalid;
    logic [31:0] s_rdata;
    logic [1:0]  pend;
    logic        err;

    always #5 clk = ~clk;

    iob_cache_fe_arbiter dut (
        .clk_i          (clk),
        .cke_i          (cke),
        .arst_n_i       (arst_n),
        .m0_iob_valid_i (m0_valid),
        .m0_iob_addr_i  (m0_addr),
        .m0_iob_wdata_i (m0_wdata),
        .m0_iob_wstrb_i (m0_wstrb),
        .m0_iob_ready_o (m0_ready),
        .m0_iob_rvalid_o(m0_rvalid),
        .m0_iob_rdata_o (m0_rdata),
        .m1_iob_valid_i (m1_valid),
        .m1_iob_addr_i  (m1_addr),
        .m1_iob_wdata_i (m1_wdata),
        .m1_iob_wstrb_i (m1_wstrb),
        .m1_iob_ready_o (m1_ready),
        .m1_iob_rvalid_o(m1_rvalid),
        .m1_iob_rdata_o (m1_rdata),
        .s_iob_valid_o  (s_valid),
        .s_iob_addr_o   (s_addr),
        .s_iob_wdata_o  (s_wdata),
        .s_iob_wstrb_o  (s_wstrb),
        .s_iob_ready_i  (s_ready),
        .s_iob_rvalid_i (s_rvalid),
        .s_iob_rdata_i  (s_rdata),
        .pend_o         (pend),
        .err_o          (err)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard ----------------
    typedef struct {
        int          cyc;
        int          gid;
        logic        v;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        r0;
        logic        r1;
        logic        rv0;
        logic        rv1;
        logic [31:0] rdata;
        logic [1:0]  pend;
    } exp_t;

    exp_t exp_q[$];

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("s_valid",   64'(s_valid),   64'(e.v));
                chk("s_addr",    64'(s_addr),    64'(e.addr));
                chk("s_wdata",   64'(s_wdata),   64'(e.wdata));
                chk("s_wstrb",   64'(s_wstrb),   64'(e.wstrb));
                chk("m0_ready",  64'(m0_ready),  64'(e.r0));
                chk("m1_ready",  64'(m1_ready),  64'(e.r1));
                chk("m0_rvalid", 64'(m0_rvalid), 64'(e.rv0));
                chk("m1_rvalid", 64'(m1_rvalid), 64'(e.rv1));
                chk("m0_rdata",  64'(m0_rdata),  64'(e.rdata));
                chk("m1_rdata",  64'(m1_rdata),  64'(e.rdata));
                chk("pend",      64'(pend),      64'(e.pend));
                chk("err",       64'(err),       64'(1'b0));
                if (e.r0 || e.r1)
                    $display("cyc %0d: accept m%0d addr=%08h wstrb=%h pend=%0d",
                             e.cyc, e.gid, e.addr, e.wstrb, e.pend);
                if (e.rv0 || e.rv1)
                    $display("cyc %0d: response to m%0d data=%08h", e.cyc, e.rv1 ? 1 : 0, e.rdata);
            end
        end
    end

    // ---------------- reference model state ----------------
    typedef struct {
        int          due;
        logic [31:0] data;
    } cresp_t;

    cresp_t      cq[$];      // cache's queue of pending read responses
    int          mq[$];      // requester IDs of outstanding reads, in issue order
    bit          act[2];
    logic [31:0] raddr[2];
    logic [31:0] rwd[2];
    logic [3:0]  rws[2];
    int          lock_id = -1;
    int          rr = 0;
    int          cyc = 0;

    task automatic step(input bit gen_en);
        exp_t   e;
        cresp_t c;
        bit     rdy;
        bit     rv;
        int     g;
        int     id;
        for (int r = 0; r < 2; r++) begin
            if (!act[r] && gen_en && $urandom_range(0, 9) < 6) begin
                act[r]   = 1'b1;
                raddr[r] = $urandom;
                rwd[r]   = $urandom;
                rws[r]   = ($urandom_range(0, 9) < 6) ? 4'h0 : 4'($urandom_range(1, 15));
            end
        end
        rdy = ($urandom_range(0, 9) < 7);
        rv  = (cq.size() > 0) && (cq[0].due <= cyc);

        m0_valid = act[0]; m0_addr = raddr[0]; m0_wdata = rwd[0]; m0_wstrb = rws[0];
        m1_valid = act[1]; m1_addr = raddr[1]; m1_wdata = rwd[1]; m1_wstrb = rws[1];
        s_ready  = rdy;
        s_rvalid = rv;
        s_rdata  = rv ? cq[0].data : $urandom;

        // Expected behaviour: a stalled request keeps the port; otherwise,
        // with room for another read, the only requester or the one whose
        // turn it is wins.
        g = -1;
        if (lock_id >= 0)
            g = lock_id;
        else if (mq.size() < DEPTH) begin
            if (act[0] && act[1]) g = rr;
            else if (act[0])      g = 0;
            else if (act[1])      g = 1;
        end

        e.cyc   = cyc;
        e.gid   = g;
        e.pend  = 2'(mq.size());
        e.v     = (g >= 0);
        e.addr  = (g >= 0) ? raddr[g] : 32'h0;
        e.wdata = (g >= 0) ? rwd[g]   : 32'h0;
        e.wstrb = (g >= 0) ? rws[g]   : 4'h0;
        e.r0    = (g == 0) && rdy;
        e.r1    = (g == 1) && rdy;
        e.rdata = s_rdata;
        e.rv0   = 1'b0;
        e.rv1   = 1'b0;
        if (rv) begin
            id    = mq.pop_front();
            e.rv0 = (id == 0);
            e.rv1 = (id == 1);
            void'(cq.pop_front());
        end
        exp_q.push_back(e);

        if (g >= 0 && rdy) begin
            rr      = 1 - g;
            lock_id = -1;
            if (rws[g] == 4'h0) begin
                mq.push_back(g);
                c.due  = cyc + 1 + $urandom_range(0, 3);
                c.data = $urandom;
                cq.push_back(c);
            end
            act[g] = 1'b0;
        end else if (g >= 0) begin
            lock_id = g;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m0_valid = 0; m0_addr = 0; m0_wdata = 0; m0_wstrb = 0;
        m1_valid = 0; m1_addr = 0; m1_wdata = 0; m1_wstrb = 0;
        s_ready = 0; s_rvalid = 0; s_rdata = 0;
    endtask

    initial begin
        int guard;
        cke = 1'b1;
        arst_n = 1'b0;
        idle_inputs();
        // Reset: outputs must be quiet even with active inputs.
        m0_valid = 1'b1; s_ready = 1'b1; s_rvalid = 1'b1; s_rdata = 32'hDEADBEEF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst s_valid",   64'(s_valid),   64'(0));
        chk("rst m0_ready",  64'(m0_ready),  64'(0));
        chk("rst m1_ready",  64'(m1_ready),  64'(0));
        chk("rst m0_rvalid", 64'(m0_rvalid), 64'(0));
        chk("rst m1_rvalid", 64'(m1_rvalid), 64'(0));
        chk("rst pend",      64'(pend),      64'(0));
        chk("rst err",       64'(err),       64'(0));
        idle_inputs();
        arst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("idle s_valid", 64'(s_valid), 64'(0));
        chk("idle pend",    64'(pend),    64'(0));

        // Random traffic, then drain.
        for (int i = 0; i < 2000; i++) step(1'b1);
        guard = 0;
        while ((act[0] || act[1] || cq.size() > 0) && guard < 300) begin
            step(1'b0);
            guard++;
        end
        chk("drain timeout", 64'(guard < 300), 64'(1));
        idle_inputs();
        @(negedge clk);
        chk("drained pend", 64'(pend), 64'(0));

        // Unsolicited rvalid: ignored while cke=0, then latches err.
        @(posedge clk); #1;
        cke = 1'b0; s_rvalid = 1'b1; s_rdata = 32'h12345678;
        @(negedge clk);
        chk("unsol m0_rvalid", 64'(m0_rvalid), 64'(0));
        chk("unsol m1_rvalid", 64'(m1_rvalid), 64'(0));
        @(posedge clk); #1;
        chk("cke0 err", 64'(err), 64'(0));
        cke = 1'b1;
        @(posedge clk); #1;
        s_rvalid = 1'b0;
        chk("err set", 64'(err), 64'(1));
        repeat (3) @(posedge clk);
        #1;
        chk("err sticky", 64'(err), 64'(1));

        // A write is accepted and does not count as outstanding.
        m0_valid = 1'b1; m0_addr = 32'h200; m0_wdata = 32'hCAFEF00D; m0_wstrb = 4'hF; s_ready = 1'b1;
        @(negedge clk);
        chk("wr m0_ready", 64'(m0_ready), 64'(1));
        chk("wr s_wstrb",  64'(s_wstrb),  64'(4'hF));
        @(posedge clk); #1;
        idle_inputs();
        $display("write accepted addr=00000200 pend=%0d", pend);
        chk("wr pend", 64'(pend), 64'(0));

        // Reset clears the sticky error.
        arst_n = 1'b0;
        #1;
        chk("rst clears err", 64'(err), 64'(0));
        @(posedge clk); #1;
        arst_n = 1'b1;
        @(posedge clk); #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/iob_cache_fe_arbiter.md
# iob_cache_fe_arbiter

Two-requester arbiter that shares the single IOb front-end port of the cache (`iob_cache_front_end`) between requester 0 and requester 1, for example the instruction and data buses of a CPU. It grants the cache port round-robin, locks the grant while a request is waiting for `ready`, and keeps an in-order FIFO of requester IDs for outstanding reads. Each `rvalid`/`rdata` response is routed back to the requester that issued it. It sits directly between the requesters and the cache's `iob_s` port.

## Interface
- `ADDR_W`, 32, byte address width (includes the cache's CTRL select bit when `USE_CTRL`=1).
- `DATA_W`, 32, data width; `DATA_W/8` strobe bits.
- `PEND_W`, 1, log2 of the read-ID FIFO depth; depth = 2^`PEND_W` outstanding reads.
- `clk_i`  in  1  clock.
- `cke_i`  in  1  clock enable; when 0, every register holds its value.
- `arst_n_i`  in  1  reset, asynchronous, active-low.
- `m0_iob_valid_i`, `m1_iob_valid_i`  in  1  request valid, requester 0/1.
- `m0_iob_addr_i`, `m1_iob_addr_i`  in  `ADDR_W`  address.
- `m0_iob_wdata_i`, `m1_iob_wdata_i`  in  `DATA_W`  write data.
- `m0_iob_wstrb_i`, `m1_iob_wstrb_i`  in  `DATA_W/8`  write strobes; all-zero means a read.
- `m0_iob_ready_o`, `m1_iob_ready_o`  out  1  request accepted this cycle.
- `m0_iob_rvalid_o`, `m1_iob_rvalid_o`  out  1  read data valid.
- `m0_iob_rdata_o`, `m1_iob_rdata_o`  out  `DATA_W`  read data; both equal `s_iob_rdata_i`.
- `s_iob_valid_o`  out  1  request to the cache.
- `s_iob_addr_o`  out  `ADDR_W`  address to the cache.
- `s_iob_wdata_o`  out  `DATA_W`  write data to the cache.
- `s_iob_wstrb_o`  out  `DATA_W/8`  write strobes to the cache.
- `s_iob_ready_i`  in  1  cache accepts the request.
- `s_iob_rvalid_i`  in  1  cache read response valid.
- `s_iob_rdata_i`  in  `DATA_W`  cache read data.
- `pend_o`  out  `PEND_W+1`  number of outstanding reads.
- `err_o`  out  1  sticky flag: `rvalid` arrived while the FIFO was empty.

## Operation
- Registers:
  - `prio`: 0 selects m0 first, 1 selects m1 first.
  - FSM with states IDLE and HOLD.
  - `gnt_r`: the locked grant.
  - ID FIFO with read and write pointers, plus the count `pend`.
  - `err`.
- `full` = (`pend` == 2^`PEND_W`).
- IDLE, grant selection:
  - If `full`: no grant; `s_iob_valid_o`=0. Writes also stall, to keep ordering simple.
  - Else if only one requester is valid: grant it.
  - Else if both are valid: grant `prio`.
- HOLD: the grant is `gnt_r` and ignores the other requester.
- Forwarding: `s_iob_valid/addr/wdata/wstrb_o` = the granted requester's inputs, or 0 if there is no grant. The granted requester's `ready_o` = `s_iob_ready_i`; the other requester's `ready_o` = 0.
- Accept = `s_iob_valid_o` & `s_iob_ready_i`. On accept:
  - `prio` ← the other requester.
  - If wstrb == 0: push the granted ID into the FIFO.
  - The FSM goes to or stays in IDLE.
- Grant made without accept: the FSM enters HOLD with `gnt_r` ← grant. It stays in HOLD until accept.
- If the held requester drops valid (protocol violation): return to IDLE and leave `prio` unchanged.
- Response path:
  - `s_iob_rvalid_i` with `pend`>0: pop the FIFO.
  - `mX_iob_rvalid_o` = `s_iob_rvalid_i` & (head == X).
  - `s_iob_rvalid_i` with `pend`==0: set `err`; no requester sees `rvalid`.
- Simultaneous push and pop: `pend` unchanged. The pop refers to the pre-push head, because the cache never returns `rvalid` in the acceptance cycle.
- Pointers are `PEND_W` bits wide and wrap modulo the FIFO depth. `pend` is `PEND_W+1` bits wide and ranges 0..depth.

## Timing
- Request forwarding is combinational: zero cycles from requester to cache, zero cycles from `ready` back.
- The response route is combinational from `s_iob_rvalid_i` through the FIFO head register.
- `prio`, FSM, FIFO and `err` update on the `clk_i` rising edge only when `cke_i`=1.
- Reset (`arst_n_i`=0) is asynchronous and forces: `prio`=0, FSM=IDLE, FIFO empty, `pend_o`=0, `err_o`=0.
- During reset, every output is 0: `s_iob_valid_o`=0, all `ready_o`=0, all `rvalid_o`=0.
- Reset mid-operation discards outstanding IDs. The cache must be reset together with the arbiter.
- Back-to-back accepts every cycle are supported while the FIFO is not full.

## Test plan
- Reset and idle: hold `arst_n_i` low, then release. All outputs are 0, `pend_o`=0.
- Single requester: m0 reads 0x100, cache `ready` in the same cycle, `rvalid` 1 cycle later with 0xDEADBEEF. `m0_iob_rvalid_o`=1 with that data, m1 sees no `rvalid`, `pend_o` goes 1 then 0.
- Contention: m0 and m1 both request continuously, `ready`=1. Grants go m0, m1, m0, m1 on consecutive cycles.
- Grant lock: m0 requests, cache `ready`=0 for 3 cycles while m1 also asserts valid. Address stays at m0's for all 3 cycles; m1 is granted the cycle after m0's accept.
- FIFO full, `PEND_W`=1: two reads accepted with no responses. A third request sees `s_iob_valid_o`=0 until the first `rvalid`; responses route m0 then m1 in issue order.
- Writes and error: a write (wstrb=0xF) is accepted and `pend_o` stays 0. An unsolicited `s_iob_rvalid_i` sets `err_o`=1, which stays set until reset.
